// File: rtl/bmlp_pkg.sv
// Shared types and constants for the binary-MLP neuron datapath.
package bmlp_pkg;

    // Signed 7-bit accumulator / partial-sum value.
    typedef logic signed [6:0] acc7_t;

    // Clamp limits applied when an accumulate step overflows.
    localparam acc7_t ACC_MAX = 7'sd63;
    localparam acc7_t ACC_MIN = -7'sd64;

    // Per-neuron run state.
    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } neuron_state_t;

endpackage

// File: rtl/neuron_acc_7b_if.sv
// Partial-sum input stream and result output stream of one neuron stage.
interface neuron_acc_7b_if;
    import bmlp_pkg::*;

    logic  in_valid;
    logic  in_ready;
    acc7_t in_data;
    logic  out_valid;
    logic  out_ready;
    acc7_t out_acc;
    logic  out_bit;
    logic  out_sat;

    // Producer of partial sums and consumer of results.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_acc, out_bit, out_sat
    );

    // The accumulate stage itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_acc, out_bit, out_sat
    );

endinterface

// File: rtl/adder_7b.sv
// 7-bit two's-complement adder with carry-in and signed-overflow flag.
module adder_7b (
    input  logic [6:0] a,
    input  logic [6:0] b,
    input  logic       cin,
    output logic [6:0] s,
    output logic       overflow
);

    assign s = a + b + {6'b0, cin};

    // Overflow: both operands share a sign that the result does not.
    assign overflow = (a[6] == b[6]) && (s[6] != a[6]);

endmodule

// File: rtl/neuron_acc_7b.sv
// Accumulate-and-activate stage: bias + N_TERMS partial sums, clamped on
// overflow, result presented with its sign activation bit.
module neuron_acc_7b
    import bmlp_pkg::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  acc7_t          bias,
    output logic           busy,
    neuron_acc_7b_if.slave bus
);

    localparam int               CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    neuron_state_t    state;
    acc7_t            acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic [6:0] sum;
    logic       ovf;
    acc7_t      acc_next;
    logic       done;

    adder_7b u_adder (
        .a        (acc),
        .b        (bus.in_data),
        .cin      (1'b0),
        .s        (sum),
        .overflow (ovf)
    );

    // Clamp toward the operands' common sign when the add overflows.
    always_comb begin
        // NOTE: default assignment first so no path leaves acc_next unassigned (no latch).
        acc_next = acc7_t'(sum);
        if (ovf) begin
            acc_next = acc[6] ? ACC_MIN : ACC_MAX;
        end
    end

    // Run FSM with accumulator, beat counter and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias;
                        cnt   <= '0;
                        sat   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (ovf) begin
                            sat <= 1'b1;
                        end
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        if (start) begin
                            acc   <= bias;
                            cnt   <= '0;
                            sat   <= 1'b0;
                            state <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only; result fields zero unless valid.
    assign done          = (state == DONE);
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = done;
    assign busy          = (state != IDLE);
    assign bus.out_acc   = done ? acc : '0;
    assign bus.out_bit   = done & ~acc[6];
    assign bus.out_sat   = done & sat;

endmodule

// File: tb/tb_neuron_acc_7b.sv
// Directed self-checking bench for neuron_acc_7b with N_TERMS=4.
module tb_neuron_acc_7b;
    import bmlp_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    acc7_t bias;
    logic  busy;
    int    checks = 0;
    int    failures = 0;

    neuron_acc_7b_if bus ();

    neuron_acc_7b #(.N_TERMS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bias  (bias),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input acc7_t b);
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = '0;
    endtask

    task automatic beat(input acc7_t d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Starts a run and feeds three beats; the caller feeds the last one.
    task automatic run_three(input acc7_t b, input acc7_t d0, input acc7_t d1, input acc7_t d2);
        start_run(b);
        beat(d0);
        beat(d1);
        beat(d2);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready, busy, bus.out_bit, bus.out_sat} !== 5'b0 || bus.out_acc !== 7'sd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b r=%b busy=%b bit=%b sat=%b acc=%0d want all 0",
                     bus.out_valid, bus.in_ready, busy, bus.out_bit, bus.out_sat, bus.out_acc);
        end
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 7'sd5;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b000) begin
            failures++;
            $display("FAIL idle_ignores_in_valid: got v/r/busy=%b want 000",
                     {bus.out_valid, bus.in_ready, busy});
        end
    endtask

    task automatic test_basic();
        start_run(7'sd0);
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b011) begin
            failures++;
            $display("FAIL basic_accum_entry: got v/r/busy=%b want 011", {bus.out_valid, bus.in_ready, busy});
        end
        beat(7'sd10);
        beat(7'sd20);
        beat(-7'sd10);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got out_valid=%b want 0", bus.out_valid);
        end
        beat(7'sd5);
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b101) begin
            failures++;
            $display("FAIL basic_latency: got v/r/busy=%b want 101", {bus.out_valid, bus.in_ready, busy});
        end
        checks++;
        if (bus.out_acc !== 7'sd25 || bus.out_bit !== 1'b1 || bus.out_sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got acc=%0d bit=%b sat=%b want acc=25 bit=1 sat=0",
                     bus.out_acc, bus.out_bit, bus.out_sat);
        end
        drain();
        checks++;
        if ({bus.out_valid, busy} !== 2'b00 || bus.out_acc !== 7'sd0) begin
            failures++;
            $display("FAIL basic_handoff: got v=%b busy=%b acc=%0d want 0 0 0", bus.out_valid, busy, bus.out_acc);
        end
    endtask

    task automatic test_pos_sat();
        run_three(7'sd40, 7'sd50, -7'sd13, -7'sd24);
        beat(7'sd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 7'sd26 || bus.out_bit !== 1'b1 || bus.out_sat !== 1'b1) begin
            failures++;
            $display("FAIL pos_sat: got v=%b acc=%0d bit=%b sat=%b want v=1 acc=26 bit=1 sat=1",
                     bus.out_valid, bus.out_acc, bus.out_bit, bus.out_sat);
        end
        drain();
    endtask

    task automatic test_neg_sat();
        run_three(-7'sd60, -7'sd51, 7'sd43, 7'sd0);
        beat(7'sd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== -7'sd21 || bus.out_bit !== 1'b0 || bus.out_sat !== 1'b1) begin
            failures++;
            $display("FAIL neg_sat: got v=%b acc=%0d bit=%b sat=%b want v=1 acc=-21 bit=0 sat=1",
                     bus.out_valid, bus.out_acc, bus.out_bit, bus.out_sat);
        end
        drain();
    endtask

    task automatic test_backpressure();
        start_run(7'sd1);
        for (int i = 0; i < 4; i++) begin
            beat(acc7_t'(i + 2));
            if (i < 3) begin
                tick();
                tick();
                checks++;
                if ({bus.out_valid, bus.in_ready, busy} !== 3'b011) begin
                    failures++;
                    $display("FAIL gap_%0d: got v/r/busy=%b want 011", i, {bus.out_valid, bus.in_ready, busy});
                end
            end
        end
        // Hold the result with noise on in_valid and start.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 7'sd50;
            start        = i[0];
            bias         = -7'sd30;
            checks++;
            if ({bus.out_valid, bus.in_ready, busy} !== 3'b101 || bus.out_acc !== 7'sd15 ||
                bus.out_bit !== 1'b1 || bus.out_sat !== 1'b0) begin
                failures++;
                $display("FAIL hold_%0d: got v/r/busy=%b acc=%0d bit=%b sat=%b want 101 acc=15 bit=1 sat=0",
                         i, {bus.out_valid, bus.in_ready, busy}, bus.out_acc, bus.out_bit, bus.out_sat);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        bias         = '0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 7'sd15) begin
            failures++;
            $display("FAIL hold_final: got v=%b acc=%0d want v=1 acc=15", bus.out_valid, bus.out_acc);
        end
        drain();
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b000) begin
            failures++;
            $display("FAIL backpressure_idle: got v/r/busy=%b want 000", {bus.out_valid, bus.in_ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        run_three(7'sd3, 7'sd1, 7'sd1, 7'sd1);
        beat(7'sd1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 7'sd7) begin
            failures++;
            $display("FAIL b2b_first: got v=%b acc=%0d want v=1 acc=7", bus.out_valid, bus.out_acc);
        end
        bus.out_ready = 1'b1;
        start         = 1'b1;
        bias          = -7'sd5;
        tick();
        bus.out_ready = 1'b0;
        start         = 1'b0;
        bias          = '0;
        checks++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b011) begin
            failures++;
            $display("FAIL b2b_no_bubble: got v/r/busy=%b want 011", {bus.out_valid, bus.in_ready, busy});
        end
        for (int i = 0; i < 4; i++) begin
            beat(7'sd0);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== -7'sd5 || bus.out_bit !== 1'b0 || bus.out_sat !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got v=%b acc=%0d bit=%b sat=%b want v=1 acc=-5 bit=0 sat=0",
                     bus.out_valid, bus.out_acc, bus.out_bit, bus.out_sat);
        end
        drain();
    endtask

    task automatic test_async_reset();
        run_three(7'sd20, 7'sd10, 7'sd10, 7'sd10);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, busy, bus.out_bit, bus.out_sat} !== 5'b0 || bus.out_acc !== 7'sd0) begin
            failures++;
            $display("FAIL async_reset: got v=%b r=%b busy=%b bit=%b sat=%b acc=%0d want all 0",
                     bus.out_valid, bus.in_ready, busy, bus.out_bit, bus.out_sat, bus.out_acc);
        end
        #2;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 7'sd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, busy} !== 2'b00) begin
                failures++;
                $display("FAIL post_reset_idle_%0d: got v=%b busy=%b want 0 0", i, bus.out_valid, busy);
            end
        end
        bus.in_valid = 1'b0;
        run_three(7'sd7, 7'sd1, 7'sd1, 7'sd1);
        beat(7'sd1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_acc !== 7'sd11 || bus.out_bit !== 1'b1 || bus.out_sat !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_run: got v=%b acc=%0d bit=%b sat=%b want v=1 acc=11 bit=1 sat=0",
                     bus.out_valid, bus.out_acc, bus.out_bit, bus.out_sat);
        end
        drain();
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        bias          = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_acc_7b.md
Name: neuron_acc_7b

Overview:
Sequential accumulate-and-activate stage for one binary-MLP neuron, sitting directly downstream of the 7-bit signed adder.
- Loads a signed bias, then accepts a stream of N_TERMS signed 7-bit partial sums over a valid/ready handshake.
- Accumulates them through an adder_7b instance, clamping on overflow.
- Presents the final sum and its sign activation bit on a valid/ready output.

Parameters:
N_TERMS, 8, number of partial-sum beats per neuron; legal range 1..127.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; loads bias and begins a run
bias  in  7  signed two's-complement initial accumulator value
in_valid  in  1  partial sum present on in_data
in_ready  out  1  block accepts a partial sum this cycle
in_data  in  7  signed partial sum
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
out_acc  out  7  signed final accumulator value
out_bit  out  1  sign activation: 1 if out_acc >= 0, else 0
out_sat  out  1  sticky: saturation occurred during this run
busy  out  1  high in ACCUM and DONE

Behaviour:
- Reset: async on rst_n low, regardless of clk. State IDLE; acc, cnt and sat all 0. Every output 0.
- Reset mid-run: the partial result is discarded and no out_valid is produced.
- States: IDLE, ACCUM, DONE. All outputs are decoded from registered state, with no combinational path from inputs to outputs.
- IDLE: in_ready=0, busy=0, out_valid=0.
  - start=1 -> acc<=bias, cnt<=0, sat<=0, next state ACCUM.
  - in_valid is ignored.
- ACCUM: in_ready=1, busy=1.
  - A beat is accepted when in_valid & in_ready.
  - Sum = adder_7b(A=acc, B=in_data, Cin=0).
  - If overflow=0: acc<=S.
  - If overflow=1: acc<=+63 when acc[6]=0, else -64; sat<=1.
  - Each accepted beat increments cnt.
  - The beat with cnt==N_TERMS-1 moves the state to DONE.
  - Cycles with in_valid=0 change nothing. start is ignored.
  - Accumulation continues from the clamped value, so later beats may bring acc back into range; sat stays 1.
- DONE: out_valid=1, in_ready=0, busy=1.
  - Outputs: out_acc=acc, out_bit=~acc[6], out_sat=sat.
  - These stay stable while out_ready=0.
  - out_ready=1 with start=0 -> IDLE.
  - out_ready=1 with start=1 -> result handed off, bias loaded, straight to ACCUM with no bubble.
  - start with out_ready=0 is ignored.
- out_acc, out_bit and out_sat are forced to 0 whenever out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. it is visible in the cycle after that beat.
- Minimum run: N_TERMS+1 cycles from start to out_valid.
- N_TERMS=1: the first accepted beat goes directly to DONE.
- cnt width: $clog2(N_TERMS+1), which cannot wrap within a run.

Decomposition:
- Shared package bmlp_pkg holds:
  - acc7_t, a signed 7-bit typedef
  - ACC_MAX = 7'sd63 and ACC_MIN = -7'sd64
  - the neuron_state_t enum {IDLE, ACCUM, DONE}
- One sub-module: the existing adder_7b, instantiated once with Cin tied 0.
- Saturation select, counter and FSM live in neuron_acc_7b.

Test Plan:
1. Basic run, N_TERMS=4: bias=0, data 10, 20, -10, 5, back-to-back -> out_valid one cycle after the 4th beat; out_acc=25, out_bit=1, out_sat=0.
2. Positive saturation: bias=40, data 50, -13, -24, 0 -> acc clamps to 63 after beat 1; final out_acc=26, out_bit=1, out_sat=1.
3. Negative saturation: bias=-60, data -51, 43, 0, 0 -> clamp to -64, then final out_acc=-21, out_bit=0, out_sat=1.
4. Backpressure and gaps:
   - Insert 2-cycle in_valid gaps, then hold out_ready=0 for 5 cycles in DONE.
   - Required: outputs stable and in_ready=0 throughout DONE.
   - Extra in_valid beats and start pulses are ignored; result unchanged when out_ready rises.
5. Back-to-back: in DONE, assert out_ready=1 and start=1 with bias=-5 in the same cycle -> next cycle out_valid=0, busy=1, in_ready=1, acc=-5; a run of four zeros yields out_acc=-5, out_bit=0.
6. Async reset: drop rst_n between clock edges after the 3rd beat of a run -> all outputs 0 immediately; after release, start with bias=7 and data 1, 1, 1, 1 -> out_acc=11, out_sat=0.
